// File: rtl/game_pkg.sv
// game_pkg: shared screen constants, slot index type, FSM encoding and a saturating subtract
package game_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PARK_X   = 1023;
    localparam int PARK_Y   = 511;
    localparam int BORDER   = 31;
    localparam int PROJ_W   = 4;

    typedef logic [1:0] slot_idx_t;

    localparam logic [0:0] READY    = 1'b0;
    localparam logic [0:0] COOLDOWN = 1'b1;

    function automatic logic [8:0] sat_sub(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? 9'd0 : 9'(a - b);
    endfunction
endpackage

// File: rtl/player_proj_scheduler_if.sv
// player_proj_scheduler_if: player inputs, detector feedback and slot position outputs
interface player_proj_scheduler_if;
    import game_pkg::*;
    logic       frame_tick;
    logic       fire_btn;
    logic [9:0] playerX;
    logic [8:0] playerY;
    logic       projHit;
    slot_idx_t  collidedProj;
    logic [9:0] proj1X, proj2X, proj3X;
    logic [8:0] proj1Y, proj2Y, proj3Y;
    logic [2:0] proj_active;
    logic       fire_ack;
    logic [7:0] shots_fired;

    modport master (
        output frame_tick, fire_btn, playerX, playerY, projHit, collidedProj,
        input  proj1X, proj2X, proj3X, proj1Y, proj2Y, proj3Y, proj_active, fire_ack, shots_fired
    );
    modport slave (
        input  frame_tick, fire_btn, playerX, playerY, projHit, collidedProj,
        output proj1X, proj2X, proj3X, proj1Y, proj2Y, proj3Y, proj_active, fire_ack, shots_fired
    );
endinterface

// File: rtl/player_proj_scheduler_slot.sv
// proj_slot: one projectile slot holding position, live flag and post-retire holdoff
module proj_slot
    import game_pkg::*;
#(
    parameter logic [8:0] SPEED  = 9'd4,
    parameter logic [9:0] HOME_X = 10'(PARK_X),
    parameter logic [8:0] HOME_Y = 9'(PARK_Y)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn_i,
    input  logic [9:0] spawn_x_i,
    input  logic [8:0] spawn_y_i,
    input  logic       move_i,
    input  logic       retire_i,
    output logic [9:0] x_o,
    output logic [8:0] y_o,
    output logic       active_o,
    output logic       holdoff_o
);
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       active_q, active_d, holdoff_q, kill;

    assign kill = retire_i & active_q;

    // retire wins over spawn and movement; movement saturates at the top of the screen
    always_comb begin
        x_d      = kill ? HOME_X : spawn_i ? spawn_x_i : x_q;
        y_d      = kill ? HOME_Y : spawn_i ? spawn_y_i : (move_i & active_q) ? sat_sub(y_q, SPEED) : y_q;
        active_d = ~kill & (active_q | spawn_i);
    end

    // slot state; holdoff marks the cycle right after a retire so a stale hit report is absorbed
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= HOME_X;
            y_q       <= HOME_Y;
            active_q  <= 1'b0;
            holdoff_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            active_q  <= active_d;
            holdoff_q <= kill;
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign active_o  = active_q;
    assign holdoff_o = holdoff_q;
endmodule

// File: rtl/player_proj_scheduler.sv
// player_proj_scheduler: fire edge detect, slot allocation, cooldown FSM and shot counter for three projectile slots
module player_proj_scheduler
    import game_pkg::*;
#(
    parameter int PROJ_SPEED     = 4,
    parameter int PROJ_W         = game_pkg::PROJ_W,
    parameter int PROJ_H         = 8,
    parameter int PLAYER_W       = 32,
    parameter int COOLDOWN_TICKS = 8,
    parameter int PARK_X         = game_pkg::PARK_X,
    parameter int PARK_Y         = game_pkg::PARK_Y
) (
    input logic                    clk,
    input logic                    rst,
    player_proj_scheduler_if.slave bus
);
    logic       fire_prev_q, fire_rise, accept, ack_q;
    logic [0:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d, shots_q;
    logic [2:0] active, holdoff, elig, spawn;
    logic [9:0] xs [3];
    logic [8:0] ys [3];
    logic [10:0] sx_sum;
    logic [9:0] spawn_x;
    logic [8:0] spawn_y;

    assign fire_rise = bus.fire_btn & ~fire_prev_q;
    assign elig      = ~active & ~holdoff;
    assign accept    = (state_q == READY) & fire_rise & (|elig);
    assign spawn     = accept ? (elig & (~elig + 3'd1)) : 3'd0;
    assign sx_sum    = {1'b0, bus.playerX} + 11'(PLAYER_W / 2 - PROJ_W / 2);
    assign spawn_x   = (sx_sum > 11'd1022) ? 10'd1022 : sx_sum[9:0];
    assign spawn_y   = sat_sub(bus.playerY, 9'(PROJ_H));

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_slot
            proj_slot #(
                .SPEED (9'(PROJ_SPEED)),
                .HOME_X(10'(PARK_X)),
                .HOME_Y(9'(PARK_Y))
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .spawn_i  (spawn[k]),
                .spawn_x_i(spawn_x),
                .spawn_y_i(spawn_y),
                .move_i   (bus.frame_tick),
                .retire_i (bus.projHit && (bus.collidedProj == 2'(k + 1))),
                .x_o      (xs[k]),
                .y_o      (ys[k]),
                .active_o (active[k]),
                .holdoff_o(holdoff[k])
            );
        end
    endgenerate

    // cooldown counts frame ticks after an accepted shot and reopens firing when it hits zero
    always_comb begin
        state_d = accept ? COOLDOWN
                : (state_q == COOLDOWN && bus.frame_tick && cnt_q <= 8'd1) ? READY : state_q;
        cnt_d   = accept ? 8'(COOLDOWN_TICKS)
                : (state_q == COOLDOWN && bus.frame_tick) ? cnt_q - 8'd1 : cnt_q;
    end

    // control registers; fire_prev resets high so a button held through reset never fires
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_prev_q <= 1'b1;
            state_q     <= READY;
            cnt_q       <= 8'd0;
            shots_q     <= 8'd0;
            ack_q       <= 1'b0;
        end else begin
            fire_prev_q <= bus.fire_btn;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shots_q     <= shots_q + 8'(accept);
            ack_q       <= accept;
        end
    end

    assign bus.proj1X      = xs[0];
    assign bus.proj2X      = xs[1];
    assign bus.proj3X      = xs[2];
    assign bus.proj1Y      = ys[0];
    assign bus.proj2Y      = ys[1];
    assign bus.proj3Y      = ys[2];
    assign bus.proj_active = active;
    assign bus.fire_ack    = ack_q;
    assign bus.shots_fired = shots_q;
endmodule

// File: tb/tb_player_proj_scheduler.sv
// tb_player_proj_scheduler: directed vector table plus hand-written multi-cycle sequences
module tb_player_proj_scheduler;
    localparam int P = 1023;
    localparam int Q = 511;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    player_proj_scheduler_if bus();
    player_proj_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       r, t, f;
        logic [9:0] px;
        logic [8:0] py;
        logic       h;
        logic [1:0] cp;
        logic [2:0] act;
        logic [9:0] x1, x2, x3;
        logic [8:0] y1, y2, y3;
        logic       ack;
        logic [7:0] shots;
    } vec_t;

    vec_t tbl [14];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic t, input logic f, input logic [9:0] px,
                       input logic [8:0] py, input logic h, input logic [1:0] cp);
        @(negedge clk);
        rst = r;
        bus.frame_tick = t;
        bus.fire_btn = f;
        bus.playerX = px;
        bus.playerY = py;
        bus.projHit = h;
        bus.collidedProj = cp;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] act, input logic [9:0] x1, input logic [9:0] x2,
                       input logic [9:0] x3, input logic [8:0] y1, input logic [8:0] y2, input logic [8:0] y3,
                       input logic ack, input logic [7:0] shots);
        cmp({tag, ".active"}, 32'(bus.proj_active), 32'(act));
        cmp({tag, ".x1"}, 32'(bus.proj1X), 32'(x1));
        cmp({tag, ".x2"}, 32'(bus.proj2X), 32'(x2));
        cmp({tag, ".x3"}, 32'(bus.proj3X), 32'(x3));
        cmp({tag, ".y1"}, 32'(bus.proj1Y), 32'(y1));
        cmp({tag, ".y2"}, 32'(bus.proj2Y), 32'(y2));
        cmp({tag, ".y3"}, 32'(bus.proj3Y), 32'(y3));
        cmp({tag, ".ack"}, 32'(bus.fire_ack), 32'(ack));
        cmp({tag, ".shots"}, 32'(bus.shots_fired), 32'(shots));
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 2'd0);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.fire_btn = 1'b1;
        bus.playerX = '0;
        bus.playerY = '0;
        bus.projHit = 1'b0;
        bus.collidedProj = '0;

        tbl[0]  = '{1,0,1,  0,  0,0,0, 0,P,  P,  P,Q,  Q,  Q,0,0};
        tbl[1]  = '{0,0,1,300,440,0,0, 0,P,  P,  P,Q,  Q,  Q,0,0};
        tbl[2]  = '{0,0,0,300,440,0,0, 0,P,  P,  P,Q,  Q,  Q,0,0};
        tbl[3]  = '{0,0,1,300,440,0,0, 1,314,P,  P,432,Q,  Q,1,1};
        tbl[4]  = '{0,1,1,300,440,0,0, 1,314,P,  P,428,Q,  Q,0,1};
        tbl[5]  = '{0,1,0,300,440,0,0, 1,314,P,  P,424,Q,  Q,0,1};
        tbl[6]  = '{0,1,1,300,440,0,0, 1,314,P,  P,420,Q,  Q,0,1};
        tbl[7]  = '{0,1,0,300,440,0,0, 1,314,P,  P,416,Q,  Q,0,1};
        tbl[8]  = '{0,0,1,300,440,0,0, 1,314,P,  P,416,Q,  Q,0,1};
        tbl[9]  = '{0,1,0,300,440,0,0, 1,314,P,  P,412,Q,  Q,0,1};
        tbl[10] = '{0,1,0,300,440,0,0, 1,314,P,  P,408,Q,  Q,0,1};
        tbl[11] = '{0,1,0,300,440,0,0, 1,314,P,  P,404,Q,  Q,0,1};
        tbl[12] = '{0,1,0,300,440,0,0, 1,314,P,  P,400,Q,  Q,0,1};
        tbl[13] = '{0,0,1,100,200,0,0, 3,314,114,P,400,192,Q,1,2};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].f, tbl[i].px, tbl[i].py, tbl[i].h, tbl[i].cp);
            chk($sformatf("row%0d", i), tbl[i].act, tbl[i].x1, tbl[i].x2, tbl[i].x3,
                tbl[i].y1, tbl[i].y2, tbl[i].y3, tbl[i].ack, tbl[i].shots);
        end

        ticks(8);
        cyc(0, 0, 1, 10'd1015, 9'd108, 0, 2'd0);
        chk("third_clamp", 3'd7, 314, 114, 1022, 368, 160, 100, 1, 3);
        ticks(8);
        chk("drain2", 3'd7, 314, 114, 1022, 336, 128, 68, 0, 3);
        cyc(0, 0, 1, 10'd0, 9'd0, 0, 2'd0);
        chk("full_drop", 3'd7, 314, 114, 1022, 336, 128, 68, 0, 3);
        cyc(0, 0, 0, 10'd0, 9'd0, 1, 2'd2);
        chk("retire2", 3'd5, 314, P, 1022, 336, Q, 68, 0, 3);
        cyc(0, 0, 1, 10'd0, 9'd0, 0, 2'd0);
        chk("holdoff_drop", 3'd5, 314, P, 1022, 336, Q, 68, 0, 3);
        cyc(0, 0, 0, 10'd0, 9'd0, 0, 2'd0);
        cyc(0, 0, 1, 10'd0, 9'd0, 0, 2'd0);
        chk("realloc2_y0", 3'd7, 314, 14, 1022, 336, 0, 68, 1, 4);
        ticks(8);
        chk("drain3_sat", 3'd7, 314, 14, 1022, 304, 0, 36, 0, 4);
        cyc(0, 1, 1, 10'd0, 9'd0, 1, 2'd3);
        chk("retire3_tick", 3'd3, 314, 14, P, 300, 0, Q, 0, 4);
        cyc(0, 0, 0, 10'd0, 9'd0, 1, 2'd0);
        chk("hit_idx0", 3'd3, 314, 14, P, 300, 0, Q, 0, 4);
        cyc(0, 0, 1, 10'd200, 9'd450, 0, 2'd0);
        chk("alloc3_n2", 3'd7, 314, 14, 214, 300, 0, 442, 1, 5);
        ticks(8);
        cyc(0, 0, 0, 10'd0, 9'd0, 1, 2'd2);
        chk("retire2b", 3'd5, 314, P, 214, 268, Q, 410, 0, 5);
        cyc(0, 0, 0, 10'd0, 9'd0, 0, 2'd0);
        cyc(0, 0, 1, 10'd50, 9'd300, 1, 2'd1);
        chk("fire_and_retire", 3'd6, P, 64, 214, Q, 292, 410, 1, 6);
        ticks(8);
        chk("drain5", 3'd6, P, 64, 214, Q, 260, 378, 0, 6);
        cyc(0, 0, 1, 10'd300, 9'd440, 0, 2'd0);
        chk("three_live", 3'd7, 314, 64, 214, 432, 260, 378, 1, 7);
        ticks(3);
        chk("midflight", 3'd7, 314, 64, 214, 420, 248, 366, 0, 7);
        cyc(1, 0, 1, 10'd300, 9'd440, 0, 2'd0);
        chk("rst_mid", 3'd0, P, P, P, Q, Q, Q, 0, 0);
        cyc(0, 0, 1, 10'd300, 9'd440, 0, 2'd0);
        chk("held_thru_rst", 3'd0, P, P, P, Q, Q, Q, 0, 0);
        cyc(0, 0, 0, 10'd300, 9'd440, 0, 2'd0);
        cyc(0, 0, 1, 10'd300, 9'd440, 0, 2'd0);
        chk("ready_after_rst", 3'd1, 314, P, P, 432, Q, Q, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
